// File: rtl/dual_port_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dual_port_ram : true dual-port synchronous RAM, read-first, A wins ties  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module dual_port_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    output logic [DATA_W-1:0] dout_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] dout_b,
    output logic              wr_collision
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              same_addr;

    assign same_addr = (addr_a == addr_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            dout_a       <= '0;
            dout_b       <= '0;
            wr_collision <= 1'b0;
        end else begin
            // Reads sample the pre-edge array, giving read-first on both ports.
            dout_a       <= mem[addr_a];
            dout_b       <= mem[addr_b];
            wr_collision <= we_a & we_b & same_addr;
            if (we_a) begin
                mem[addr_a] <= din_a;
            end
            if (we_b && !(we_a && same_addr)) begin
                mem[addr_b] <= din_b;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dual_port_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dual_port_ram : randomized self-checking bench with reference model   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_dual_port_ram;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              we_a, we_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] din_a, din_b;
    logic [DATA_W-1:0] dout_a, dout_b;
    logic              wr_collision;

    int vectors    = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] model [DEPTH];
    logic [DATA_W-1:0] exp_a, exp_b;
    logic              exp_col;

    always #5 clk = ~clk;

    dual_port_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .we_a         (we_a),
        .addr_a       (addr_a),
        .din_a        (din_a),
        .dout_a       (dout_a),
        .we_b         (we_b),
        .addr_b       (addr_b),
        .din_b        (din_b),
        .dout_b       (dout_b),
        .wr_collision (wr_collision)
    );

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        exp_a = '0; exp_b = '0; exp_col = 1'b0;
    endtask

    // Apply one clock of stimulus and advance the model; leaves time at edge+1.
    task automatic step(input logic wa, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] da,
                        input logic wb, input logic [ADDR_W-1:0] ab, input logic [DATA_W-1:0] db);
        we_a = wa; addr_a = aa; din_a = da;
        we_b = wb; addr_b = ab; din_b = db;
        @(posedge clk);
        exp_a   = model[aa];
        exp_b   = model[ab];
        exp_col = wa && wb && (aa == ab);
        if (exp_col) begin
            model[aa] = da;
        end else begin
            if (wa) model[aa] = da;
            if (wb) model[ab] = db;
        end
        #1;
    endtask

    task automatic check_model(input string name);
        vectors++;
        if (dout_a !== exp_a || dout_b !== exp_b || wr_collision !== exp_col) begin
            miscompares++;
            $display("FAIL %s: got a=%h b=%h col=%b expected a=%h b=%h col=%b",
                     name, dout_a, dout_b, wr_collision, exp_a, exp_b, exp_col);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        we_a = 0; we_b = 0; addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
        model_clear();
        #3;
        vectors++;
        if (dout_a !== 8'h00 || dout_b !== 8'h00 || wr_collision !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got a=%h b=%h col=%b expected 00 00 0", dout_a, dout_b, wr_collision);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) step(0, ADDR_W'(i), '0, 0, ADDR_W'(DEPTH-1-i), '0);
        step(0, '0, '0, 0, '0, '0);
        vectors++;
        if (dout_a !== 8'h00 || dout_b !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_init_read: got a=%h b=%h expected 00 00", dout_a, dout_b);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(0, ADDR_W'(i), '0, 0, ADDR_W'(DEPTH-1-i), '0);
            check_model("init_sweep");
        end
    endtask

    task automatic test_cross_port();
        step(1, 4'd3, 8'hAA, 0, 4'd0, 8'h00);
        step(0, 4'd0, 8'h00, 0, 4'd3, 8'h00);
        vectors++;
        if (dout_b !== 8'hAA) begin
            miscompares++;
            $display("FAIL a_write_b_read: got %h expected AA", dout_b);
        end
        step(0, 4'd0, 8'h00, 1, 4'd5, 8'h55);
        step(0, 4'd5, 8'h00, 0, 4'd0, 8'h00);
        vectors++;
        if (dout_a !== 8'h55) begin
            miscompares++;
            $display("FAIL b_write_a_read: got %h expected 55", dout_a);
        end
        check_model("cross_port_model");
    endtask

    task automatic test_read_first();
        step(1, 4'd3, 8'h11, 0, 4'd3, 8'h00);
        vectors++;
        if (dout_a !== 8'hAA || dout_b !== 8'hAA) begin
            miscompares++;
            $display("FAIL read_first_old: got a=%h b=%h expected AA AA", dout_a, dout_b);
        end
        step(0, 4'd3, 8'h00, 0, 4'd3, 8'h00);
        vectors++;
        if (dout_a !== 8'h11 || dout_b !== 8'h11) begin
            miscompares++;
            $display("FAIL read_first_new: got a=%h b=%h expected 11 11", dout_a, dout_b);
        end
    endtask

    task automatic test_collision();
        step(1, 4'd7, 8'h0F, 1, 4'd7, 8'hF0);
        vectors++;
        if (wr_collision !== 1'b1) begin
            miscompares++;
            $display("FAIL collision_flag: got %b expected 1", wr_collision);
        end
        step(0, 4'd7, 8'h00, 0, 4'd7, 8'h00);
        vectors++;
        if (dout_a !== 8'h0F || dout_b !== 8'h0F || wr_collision !== 1'b0) begin
            miscompares++;
            $display("FAIL collision_data: got a=%h b=%h col=%b expected 0F 0F 0", dout_a, dout_b, wr_collision);
        end
        // Both ports writing, different addresses: no collision.
        step(1, 4'd9, 8'h99, 1, 4'd10, 8'hA5);
        check_model("no_collision_diff_addr");
    endtask

    task automatic test_parallel();
        step(1, 4'd0, 8'hC3, 1, 4'd15, 8'h3C);
        vectors++;
        if (wr_collision !== 1'b0) begin
            miscompares++;
            $display("FAIL parallel_flag: got %b expected 0", wr_collision);
        end
        step(0, 4'd0, 8'h00, 0, 4'd15, 8'h00);
        vectors++;
        if (dout_a !== 8'hC3 || dout_b !== 8'h3C) begin
            miscompares++;
            $display("FAIL parallel_data: got a=%h b=%h expected C3 3C", dout_a, dout_b);
        end
    endtask

    task automatic test_reset_mid_op();
        step(0, 4'd3, 8'h00, 0, 4'd5, 8'h00);
        check_model("pre_reset_read");
        // Pending write is presented when reset hits and held across an edge.
        we_a = 1; addr_a = 4'd3; din_a = 8'hFF;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (dout_a !== 8'h00 || dout_b !== 8'h00 || wr_collision !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got a=%h b=%h col=%b expected 00 00 0", dout_a, dout_b, wr_collision);
        end
        model_clear();
        @(posedge clk);
        #1 rst_n = 1'b1; we_a = 0;
        step(0, 4'd3, 8'h00, 0, 4'd5, 8'h00);
        step(0, 4'd7, 8'h00, 0, 4'd3, 8'h00);
        vectors++;
        if (dout_a !== 8'h00 || dout_b !== 8'h00) begin
            miscompares++;
            $display("FAIL post_reset_read: got a=%h b=%h expected 00 00", dout_a, dout_b);
        end
        check_model("post_reset_model");
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] aa, ab;
        for (int n = 0; n < 400; n++) begin
            aa = ADDR_W'($urandom_range(0, DEPTH-1));
            ab = ($urandom_range(0, 3) == 0) ? aa : ADDR_W'($urandom_range(0, DEPTH-1));
            step(1'($urandom_range(0, 1)), aa, DATA_W'($urandom),
                 1'($urandom_range(0, 1)), ab, DATA_W'($urandom));
            check_model("random");
        end
    endtask

    initial begin
        test_reset();
        test_cross_port();
        test_read_first();
        test_collision();
        test_parallel();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
